// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller: hazard sources
// observed in the ID and EX stages, and the stall/flush controls returned
// to the pipeline registers and PC.
interface pipeline_hazard_ctrl_if;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic [4:0]  IFID_Rs;
    logic [4:0]  IFID_Rt;
    logic        IFID_UsesRt;
    logic        BranchTaken;
    logic        MultiCycleStart;
    logic [3:0]  MultiCycleLen;
    logic        PCHold;
    logic        IFIDWrite;
    logic        FlushSignal;
    logic        IDEXBubble;
    logic [15:0] StallCount;

    // The pipeline datapath drives hazard sources and consumes controls.
    modport master (
        output IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt,
        output BranchTaken, MultiCycleStart, MultiCycleLen,
        input  PCHold, IFIDWrite, FlushSignal, IDEXBubble, StallCount
    );

    // The hazard controller observes hazard sources and drives controls.
    modport slave (
        input  IDEX_MemRead, IDEX_Rt, IFID_Rs, IFID_Rt, IFID_UsesRt,
        input  BranchTaken, MultiCycleStart, MultiCycleLen,
        output PCHold, IFIDWrite, FlushSignal, IDEXBubble, StallCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage in-order pipeline.
// Handles three hazard classes:
//   - taken branch/jump: flush IF/ID for FLUSH_DEPTH consecutive cycles
//   - multi-cycle op (mul/div): hold PC and IF/ID for N cycles after launch
//   - load-use: single-cycle hold with a bubble into ID/EX
// Control outputs are decoded combinationally from state and inputs so
// they act in the same cycle the hazard is seen. A saturating counter
// records how many cycles IF/ID was held.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1
) (
    input logic                  Clk,
    input logic                  Rst,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_MCWAIT = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_DEPTH - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [3:0]  cnt_r;
    logic [3:0]  next_cnt_s;
    logic [15:0] stall_count_r;

    logic        load_use_s;
    logic        pc_hold_s;
    logic        ifid_write_s;
    logic        flush_s;
    logic        idex_bubble_s;

    // A load in EX whose destination is read by the instruction in ID.
    // Register 0 is hard-wired zero and never creates a dependency.
    function automatic logic load_use_hazard(
        input logic       mem_read,
        input logic [4:0] ex_rt,
        input logic [4:0] id_rs,
        input logic [4:0] id_rt,
        input logic       id_uses_rt
    );
        load_use_hazard = mem_read && (ex_rt != 5'd0) &&
                          ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

    assign load_use_s = load_use_hazard(bus.IDEX_MemRead, bus.IDEX_Rt,
                                        bus.IFID_Rs, bus.IFID_Rt,
                                        bus.IFID_UsesRt);

    // Decode control outputs and next state from the current state and inputs.
    always_comb begin
        next_state_s  = state_r;
        next_cnt_s    = cnt_r;
        pc_hold_s     = 1'b0;
        ifid_write_s  = 1'b0;
        flush_s       = 1'b0;
        idex_bubble_s = 1'b0;

        case (state_r)
            ST_RUN: begin
                if (bus.BranchTaken) begin
                    flush_s       = 1'b1;
                    idex_bubble_s = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        next_state_s = ST_FLUSH;
                        next_cnt_s   = FLUSH_RELOAD;
                    end else begin
                        next_state_s = ST_RUN;
                        next_cnt_s   = 4'd0;
                    end
                end else if (bus.MultiCycleStart && (bus.MultiCycleLen != 4'd0)) begin
                    // Launch cycle itself lets the op enter EX; holds start next cycle.
                    next_state_s = ST_MCWAIT;
                    next_cnt_s   = bus.MultiCycleLen;
                end else if (load_use_s) begin
                    pc_hold_s     = 1'b1;
                    ifid_write_s  = 1'b1;
                    idex_bubble_s = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_MCWAIT: begin
                pc_hold_s     = 1'b1;
                ifid_write_s  = 1'b1;
                idex_bubble_s = 1'b1;
                if (cnt_r <= 4'd1) begin
                    next_state_s = ST_RUN;
                    next_cnt_s   = 4'd0;
                end else begin
                    next_cnt_s = cnt_r - 4'd1;
                end
            end
            ST_FLUSH: begin
                flush_s       = 1'b1;
                idex_bubble_s = 1'b1;
                if (cnt_r <= 4'd1) begin
                    next_state_s = ST_RUN;
                    next_cnt_s   = 4'd0;
                end else begin
                    next_cnt_s = cnt_r - 4'd1;
                end
            end
            default: begin
                next_state_s = ST_RUN;
                next_cnt_s   = 4'd0;
            end
        endcase

        // Reset suppresses every control so an aborted sequence leaves no stall.
        if (Rst) begin
            pc_hold_s     = 1'b0;
            ifid_write_s  = 1'b0;
            flush_s       = 1'b0;
            idex_bubble_s = 1'b0;
        end else begin
            pc_hold_s = pc_hold_s;
        end
    end

    // State and sequence counter update.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_r <= ST_RUN;
            cnt_r   <= 4'd0;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Saturating count of cycles in which IF/ID was held.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            stall_count_r <= 16'd0;
        end else if (ifid_write_s && (stall_count_r != 16'hFFFF)) begin
            stall_count_r <= stall_count_r + 16'd1;
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign bus.PCHold      = pc_hold_s;
    assign bus.IFIDWrite   = ifid_write_s;
    assign bus.FlushSignal = flush_s;
    assign bus.IDEXBubble  = idex_bubble_s;
    assign bus.StallCount  = stall_count_r;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. A driver applies one
// stimulus vector per cycle and pushes the reference model's expected
// outputs into a scoreboard queue; an independent monitor pops and
// compares at the falling edge.
module tb_pipeline_hazard_ctrl;

    localparam int DEPTH = 2;

    logic Clk = 1'b0;
    logic Rst;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl #(.FLUSH_DEPTH(DEPTH)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    typedef struct {
        bit pch;
        bit ifw;
        bit fl;
        bit bub;
        int cnt;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    // Reference model: future cycles already committed by an accepted
    // branch or multi-cycle op are kept as a queue of forced actions
    // (1 = flush cycle, 2 = hold cycle).
    int forced_q[$];
    int model_count = 0;

    int errors = 0;
    int checks = 0;

    task automatic cycle(input bit rst, input bit mr, input int ex_rt,
                         input int rs, input int rt, input bit uses,
                         input bit br, input bit mcs, input int len,
                         input string tag);
        exp_t e;
        bit   lu;
        int   kind;
        @(posedge Clk);
        #1;
        Rst                 = rst;
        bus.IDEX_MemRead    = mr;
        bus.IDEX_Rt         = 5'(ex_rt);
        bus.IFID_Rs         = 5'(rs);
        bus.IFID_Rt         = 5'(rt);
        bus.IFID_UsesRt     = uses;
        bus.BranchTaken     = br;
        bus.MultiCycleStart = mcs;
        bus.MultiCycleLen   = 4'(len);

        lu = mr && (ex_rt != 0) && ((ex_rt == rs) || (uses && ex_rt == rt));
        e = '{pch: 1'b0, ifw: 1'b0, fl: 1'b0, bub: 1'b0, cnt: model_count};
        if (rst) begin
            forced_q.delete();
        end else if (forced_q.size() > 0) begin
            kind = forced_q.pop_front();
            if (kind == 1) begin
                e.fl = 1'b1; e.bub = 1'b1;
            end else begin
                e.pch = 1'b1; e.ifw = 1'b1; e.bub = 1'b1;
            end
        end else if (br) begin
            e.fl = 1'b1; e.bub = 1'b1;
            for (int k = 0; k < DEPTH - 1; k++) forced_q.push_back(1);
        end else if (mcs && len != 0) begin
            for (int k = 0; k < len; k++) forced_q.push_back(2);
        end else if (lu) begin
            e.pch = 1'b1; e.ifw = 1'b1; e.bub = 1'b1;
        end

        if (rst) model_count = 0;
        else if (e.ifw && model_count < 65535) model_count = model_count + 1;

        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic idle(input string tag);
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, tag);
    endtask

    // Monitor: compare the DUT against the oldest pending expectation.
    always @(negedge Clk) begin
        exp_t  e;
        string t;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            checks = checks + 1;
            if ({bus.PCHold, bus.IFIDWrite, bus.FlushSignal, bus.IDEXBubble} !==
                {e.pch, e.ifw, e.fl, e.bub}) begin
                errors = errors + 1;
                $display("FAIL %s ctrl: got pch/ifw/fl/bub=%b%b%b%b want %b%b%b%b at %0t",
                         t, bus.PCHold, bus.IFIDWrite, bus.FlushSignal, bus.IDEXBubble,
                         e.pch, e.ifw, e.fl, e.bub, $time);
            end
            checks = checks + 1;
            if (bus.StallCount !== 16'(e.cnt)) begin
                errors = errors + 1;
                $display("FAIL %s count: got StallCount=%0d want %0d at %0t",
                         t, bus.StallCount, e.cnt, $time);
            end
        end
    end

    initial begin
        Rst                 = 1'b1;
        bus.IDEX_MemRead    = 1'b0;
        bus.IDEX_Rt         = 5'd0;
        bus.IFID_Rs         = 5'd0;
        bus.IFID_Rt         = 5'd0;
        bus.IFID_UsesRt     = 1'b0;
        bus.BranchTaken     = 1'b0;
        bus.MultiCycleStart = 1'b0;
        bus.MultiCycleLen   = 4'd0;
        repeat (2) @(posedge Clk);

        // Reset state, then a single load-use stall.
        idle("reset_state");
        cycle(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 0, "load_use");
        idle("after_load_use");

        // R0 never hazards; Rt match ignored when Rt is unused.
        cycle(1'b0, 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b0, 0, "r0_no_stall");
        cycle(1'b0, 1'b1, 7, 3, 7, 1'b0, 1'b0, 1'b0, 0, "rt_unused");
        cycle(1'b0, 1'b1, 7, 3, 7, 1'b1, 1'b0, 1'b0, 0, "rt_used");

        // Multi-cycle op N=4: hazards during the wait are ignored.
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 4, "mc_launch");
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 5, 5, 5, 1'b1, 1'b1, 1'b1, 3, "mc_hold");
        idle("mc_done");
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 0, "mc_n0");
        cycle(1'b0, 1'b1, 9, 9, 0, 1'b0, 1'b0, 1'b1, 0, "mc_n0_lu");
        idle("mc_n0_after");

        // Branch with simultaneous load-use, flush spans DEPTH cycles.
        cycle(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b1, 1'b0, 0, "br_lu");
        cycle(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b1, 1'b1, 6, "br_flush2");
        cycle(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 0, "br_post_lu");

        // Reset in the second wait cycle of an N=8 op aborts it.
        cycle(1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1, 8, "mc8_launch");
        idle("mc8_hold1");
        cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, "mc8_rst");
        idle("mc8_after_rst");
        idle("mc8_after_rst2");

        // Randomized mix of all events with occasional reset.
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  $urandom_range(0, 1),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 6)), "random");
        end

        // Saturation: continuous load-use for 65540 cycles.
        cycle(1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 0, "sat_rst");
        for (int i = 0; i < 65540; i++)
            cycle(1'b0, 1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 0, "saturate");
        idle("sat_hold");
        idle("sat_end");

        repeat (3) @(negedge Clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Parameters
REQ-001 The block SHALL have parameter FLUSH_DEPTH, default 1, legal 1..3: number of consecutive cycles FlushSignal is asserted per taken branch.

Interface
REQ-002 The block SHALL have port Clk, input, 1, rising-edge clock.
REQ-003 The block SHALL have port Rst, input, 1, reset, synchronous and active-high.
REQ-004 The block SHALL have port IDEX_MemRead, input, 1, instruction in EX is a load.
REQ-005 The block SHALL have port IDEX_Rt, input, 5, load destination register.
REQ-006 The block SHALL have port IFID_Rs, input, 5, ID-stage source register 1.
REQ-007 The block SHALL have port IFID_Rt, input, 5, ID-stage source register 2.
REQ-008 The block SHALL have port IFID_UsesRt, input, 1, ID instruction reads Rt.
REQ-009 The block SHALL have port BranchTaken, input, 1, branch/jump resolved taken this cycle.
REQ-010 The block SHALL have port MultiCycleStart, input, 1, multi-cycle op (mul/div) launched.
REQ-011 The block SHALL have port MultiCycleLen, input, 4, stall cycles required (N).
REQ-012 The block SHALL have port PCHold, output, 1, 1 = PC keeps value.
REQ-013 The block SHALL have port IFIDWrite, output, 1, 1 = IF/ID register holds (active-high hold).
REQ-014 The block SHALL have port FlushSignal, output, 1, 1 = IF/ID register loads zero.
REQ-015 The block SHALL have port IDEXBubble, output, 1, 1 = ID/EX control fields zeroed.
REQ-016 The block SHALL have port StallCount, output, 16, saturating count of hold cycles.

Function
REQ-017 State register SHALL hold one of RUN, MCWAIT, FLUSH; outputs SHALL be combinational from state and inputs.
REQ-018 IFIDWrite and FlushSignal SHALL never be 1 in the same cycle (downstream gives hold priority over flush).
REQ-019 Load-use hazard: IDEX_MemRead=1, IDEX_Rt!=0, and (IDEX_Rt==IFID_Rs or (IFID_UsesRt=1 and IDEX_Rt==IFID_Rt)).
REQ-020 RUN priority, highest first: BranchTaken, MultiCycleStart with N!=0, load-use hazard.
REQ-021 RUN+BranchTaken: FlushSignal=1, IDEXBubble=1, PCHold=0, IFIDWrite=0; next state FLUSH with flush counter=FLUSH_DEPTH-1 if FLUSH_DEPTH>1, else RUN.
REQ-022 FLUSH: FlushSignal=1, IDEXBubble=1, counter decrements each cycle; counter==1 -> RUN next cycle; BranchTaken, MultiCycleStart and hazards ignored.
REQ-023 RUN+MultiCycleStart, N>=1: launch cycle outputs all 0; next state MCWAIT, wait counter=N.
REQ-024 MCWAIT: PCHold=1, IFIDWrite=1, IDEXBubble=1, counter decrements; counter==1 -> RUN; total hold exactly N cycles; other inputs ignored.
REQ-025 MultiCycleStart with N=0 SHALL cause no stall; load-use check still applies that cycle.
REQ-026 RUN load-use (no higher-priority event): PCHold=1, IFIDWrite=1, IDEXBubble=1 for that single cycle; state stays RUN.
REQ-027 RUN with no event: all control outputs 0.
REQ-028 StallCount SHALL increment on each cycle IFIDWrite=1, saturating at 0xFFFF.

Reset
REQ-029 While Rst=1 at a rising edge: state RUN, flush/wait counters 0, StallCount 0x0000.
REQ-030 While Rst=1, PCHold, IFIDWrite, FlushSignal, IDEXBubble SHALL be 0; reset in MCWAIT or FLUSH aborts the sequence with no residual stall.

Verification
REQ-031 Load-use: MemRead=1, IDEX_Rt=5, IFID_Rs=5 for one cycle -> one cycle PCHold=IFIDWrite=IDEXBubble=1, StallCount 0->1.
REQ-032 R0 and Rt-unused: IDEX_Rt=0=IFID_Rs, then IDEX_Rt=7=IFID_Rt with IFID_UsesRt=0 -> no stall either cycle.
REQ-033 MultiCycleStart, N=4 -> holds exactly cycles 2..5 after launch, then RUN; StallCount=4; N=0 -> no hold.
REQ-034 FLUSH_DEPTH=2, BranchTaken + simultaneous load-use -> FlushSignal=1 two cycles, IFIDWrite=0 throughout.
REQ-035 Rst=1 in second cycle of MCWAIT (N=8) -> next cycle outputs 0, state RUN, StallCount 0.
REQ-036 Force 65540 hold cycles -> StallCount stays 0xFFFF.
